// File: rtl/bus_read_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bus_read_fifo_pkg
//
// Shared bus constants for the bus read FIFO and its sub-modules. The data
// width default lives here so the read FIFO and the bus write buffer agree on
// the bus word size without repeating the number.
//
// Contents:
//   BUS_DATA_W     default bus data width in bits
//   BUS_RD_DEPTH   default read FIFO depth (entries, power of two, >= 2)
//   is_pow2()      helper used to sanity-check depth parameters
// -----------------------------------------------------------------------------
package bus_read_fifo_pkg;

  localparam int BUS_DATA_W   = 16;
  localparam int BUS_RD_DEPTH = 4;

  // True when n is a power of two and at least 2.
  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage : bus_read_fifo_pkg

// File: rtl/bus_read_fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
//
// W-bit FIFO pointer register. The low bits index the storage array and the
// MSB acts as the wrap bit, so the pointer is allowed to roll over freely
// through 2^W without any special case.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (pointer -> 0)
//   clr    in   synchronous clear (pointer -> 0), has priority over inc
//   inc    in   advance the pointer by one
//   ptr    out  current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule : fifo_ptr

// File: rtl/bus_read_fifo.sv
// -----------------------------------------------------------------------------
// bus_read_fifo
//
// Synchronous first-word-fall-through FIFO on the read side of the bus. A bus
// producer writes with a plain write-enable; the consumer (e.g. the CPU load
// path) drains it with a valid/ready handshake. Read data arriving while the
// consumer is stalled is held instead of lost.
//
// Parameters:
//   WIDTH  data width in bits
//   DEPTH  number of entries (power of two, >= 2)
//   AW     pointer index width, derived -- do not override
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous flush; empties FIFO and clears overflow
//   we          in   write strobe
//   din         in   write data
//   full        out  count == DEPTH
//   dout        out  head entry (valid while dout_valid)
//   dout_valid  out  count != 0
//   dout_ready  in   consumer accept
//   count       out  occupied entries, 0..DEPTH
//   overflow    out  sticky, set when a write is dropped
// -----------------------------------------------------------------------------
module bus_read_fifo
  import bus_read_fifo_pkg::*;
#(
  parameter int WIDTH = BUS_DATA_W,
  parameter int DEPTH = BUS_RD_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [AW:0]      count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  // Status comes from the registered pointers only, so none of these flags
  // has a combinational path from we or dout_ready.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count      = wr_ptr - rd_ptr;
  assign dout_valid = !empty;

  // full is the pre-edge value: a write while full is dropped even when a pop
  // frees a slot in the same cycle. A flush discards everything, including
  // the concurrent write and pop.
  assign push = we && !full && !clr;
  assign pop  = dout_valid && dout_ready && !clr;
  assign drop = we && full && !clr;

  fifo_ptr #(.W(AW + 1)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(AW + 1)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // NOTE: the array is reset on purpose so dout reads 0 out of reset and after
  // a mid-stream reset; storage is small flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // First-word-fall-through: the head entry is driven straight from the array.
  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule : bus_read_fifo

// File: tb/tb_bus_read_fifo.sv
// -----------------------------------------------------------------------------
// tb_bus_read_fifo
//
// Directed self-checking bench for bus_read_fifo at WIDTH=16, DEPTH=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_bus_read_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             we;
  logic [WIDTH-1:0] din;
  logic             full;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [AW:0]      count;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  bus_read_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .we         (we),
    .din        (din),
    .full       (full),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [WIDTH-1:0] d);
    we  = 1'b1;
    din = d;
    step();
    we  = 1'b0;
  endtask

  task automatic pop1();
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
  endtask

  task automatic flush();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Watchdog: the bench has no open-ended waits, but never let it hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    clr        = 1'b0;
    we         = 1'b0;
    din        = '0;
    dout_ready = 1'b0;

    // ---- reset state ----
    step();
    check("rst_count",    32'(count),      32'd0);
    check("rst_valid",    32'(dout_valid), 32'd0);
    check("rst_full",     32'(full),       32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_dout",     32'(dout),       32'h0);
    rst_n = 1'b1;
    step();

    // ---- single write, fall-through, single pop ----
    write1(16'hA5A5);
    check("one_valid", 32'(dout_valid), 32'd1);
    check("one_dout",  32'(dout),       32'hA5A5);
    check("one_count", 32'(count),      32'd1);
    pop1();
    check("one_pop_valid", 32'(dout_valid), 32'd0);
    check("one_pop_count", 32'(count),      32'd0);

    // ready while empty has no effect
    pop1();
    check("empty_ready_count", 32'(count), 32'd0);

    // ---- fill, overflow, drain in order ----
    for (int i = 1; i <= 4; i++) write1(16'(i));
    check("fill_full",  32'(full),     32'd1);
    check("fill_count", 32'(count),    32'd4);
    check("fill_ovf0",  32'(overflow), 32'd0);
    write1(16'h0005);
    check("drop_ovf",   32'(overflow), 32'd1);
    check("drop_count", 32'(count),    32'd4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), 32'(dout), 32'(i));
      pop1();
    end
    check("drain_count", 32'(count),      32'd0);
    check("drain_valid", 32'(dout_valid), 32'd0);
    check("drain_ovf",   32'(overflow),   32'd1);

    // ---- full with simultaneous write and pop: write dropped ----
    flush();
    check("flush_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) write1(16'h0021 + 16'(i));
    we         = 1'b1;
    din        = 16'h0009;
    dout_ready = 1'b1;
    step();
    we         = 1'b0;
    dout_ready = 1'b0;
    check("fullpp_count", 32'(count),    32'd3);
    check("fullpp_ovf",   32'(overflow), 32'd1);
    check("fullpp_full",  32'(full),     32'd0);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("fullpp_drain_%0d", i), 32'(dout), 32'h0021 + 32'(i));
      pop1();
    end
    check("fullpp_empty", 32'(dout_valid), 32'd0);

    // ---- streaming push+pop across pointer wrap ----
    flush();
    write1(16'h0010);
    we         = 1'b1;
    dout_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      din = 16'h0010 + 16'(i);
      check($sformatf("stream_dout_%0d", i), 32'(dout), 32'h0010 + 32'(i - 1));
      step();
      check($sformatf("stream_count_%0d", i), 32'(count), 32'd1);
    end
    we         = 1'b0;
    dout_ready = 1'b0;
    check("stream_last", 32'(dout), 32'h0019);
    pop1();
    check("stream_end_count", 32'(count),    32'd0);
    check("stream_ovf",       32'(overflow), 32'd0);

    // ---- clr with concurrent write: everything discarded ----
    for (int i = 0; i < 4; i++) write1(16'h0030 + 16'(i));
    write1(16'h0034);
    pop1();
    check("preclr_count", 32'(count),    32'd3);
    check("preclr_ovf",   32'(overflow), 32'd1);
    clr = 1'b1;
    we  = 1'b1;
    din = 16'hBEEF;
    step();
    clr = 1'b0;
    we  = 1'b0;
    check("clr_count", 32'(count),      32'd0);
    check("clr_valid", 32'(dout_valid), 32'd0);
    check("clr_ovf",   32'(overflow),   32'd0);
    step();
    check("clr_discard_count", 32'(count), 32'd0);

    // ---- asynchronous reset mid-stream ----
    write1(16'h0055);
    write1(16'h0066);
    check("prerst_count", 32'(count), 32'd2);
    check("prerst_dout",  32'(dout),  32'h0055);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count),      32'd0);
    check("async_rst_valid", 32'(dout_valid), 32'd0);
    check("async_rst_dout",  32'(dout),       32'h0);
    step();
    rst_n = 1'b1;
    write1(16'h1234);
    check("postrst_dout",  32'(dout),       32'h1234);
    check("postrst_valid", 32'(dout_valid), 32'd1);
    check("postrst_count", 32'(count),      32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bus_read_fifo

// File: doc/bus_read_fifo.md
# bus_read_fifo

Read-side companion to the bus write buffer. It is a small synchronous first-word-fall-through FIFO. A bus-side producer writes with a simple write-enable. A consumer such as the CPU load path drains it with a valid/ready handshake. It decouples bus response timing from pipeline stalls, so read data arriving while the consumer is stalled is held rather than lost.

## Interface
Parameters:
- WIDTH, 16, data width in bits.
- DEPTH, 4, number of entries. Must be a power of two and ≥ 2.
- AW, $clog2(DEPTH), derived pointer index width. Not to be overridden.

Ports:
- clk  in  1  single clock. All logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous flush. Empties the FIFO and clears `overflow`.
- we  in  1  write strobe from the producer.
- din  in  WIDTH  write data, sampled when `we` is high.
- full  out  1  high when count == DEPTH.
- dout  out  WIDTH  head entry. Valid only while `dout_valid` is high.
- dout_valid  out  1  high when count != 0.
- dout_ready  in  1  consumer accept.
- count  out  AW+1  number of occupied entries, 0..DEPTH.
- overflow  out  1  sticky. Set when a write is dropped.

## Operation
- Storage: register array mem[DEPTH].
- Pointers: wr_ptr and rd_ptr, each AW+1 bits. The low AW bits index mem. The MSB is the wrap bit.
- Empty when wr_ptr == rd_ptr.
- Full when the pointer MSBs differ and the low AW bits are equal.
- count = wr_ptr − rd_ptr, modulo 2^(AW+1).
- push = we & ~full. On push: mem[wr_ptr[AW-1:0]] <= din, and wr_ptr increments.
- pop = dout_valid & dout_ready. On pop, rd_ptr increments.
- dout = mem[rd_ptr[AW-1:0]], combinational from the array (first-word-fall-through). When empty, dout holds the stale entry and its value is don't-care.
- `full` is evaluated before the edge, so a write while full is always dropped, even with a simultaneous pop. That dropped write sets `overflow`.
- A simultaneous push and pop when empty is impossible, because dout_valid is low. The push is accepted and count becomes 1.
- A simultaneous push and pop when 0 < count < DEPTH leaves count unchanged and advances both pointers.
- `dout_ready` while empty has no effect and is not an error.
- Pointers wrap naturally through 2^(AW+1). No special case is needed.
- `clr` has priority over push and pop. In that cycle: wr_ptr = rd_ptr = 0, overflow = 0, and the concurrent write is discarded.
- Reset values: wr_ptr = 0, rd_ptr = 0, overflow = 0, full = 0, dout_valid = 0, count = 0, mem = 0, so dout = 0.
- Reset mid-operation: all contents are lost immediately and asynchronously. Outputs take their reset values while rst_n is low.

## Timing
- Write-to-visible latency is 1 cycle. For `we` sampled at edge N into an empty FIFO, dout_valid = 1 and dout = din after edge N.
- Pop takes effect at the edge where valid & ready are both high. The next entry, or dout_valid = 0, appears after that edge.
- full, count and dout_valid are registered-pointer derived. They change only after an edge, with no combinational path from `we`.
- `dout_ready` does not combinationally affect any output.
- `overflow` rises in the cycle after the dropped write and stays high until `clr` or reset.
- Sustained throughput is 1 word per cycle with simultaneous push and pop.

## Structure
- Shared bus package holds the default data width constant so this block and the write buffer agree.
- One sub-module: `fifo_ptr`, an AW+1-bit pointer register with increment enable and sync clear. It is instantiated twice, for wr_ptr and rd_ptr.
- The array, full/empty compare and overflow flag stay in the top level.

## Test plan
Directed scenarios at WIDTH=16, DEPTH=4:
- Reset, then write 0xA5A5 once. After the edge: dout_valid=1, dout=0xA5A5, count=1. Pop once: dout_valid=0, count=0.
- Write 0x0001..0x0004 with dout_ready=0 → full=1, count=4. A fifth write of 0x0005 → dropped, overflow=1. Drain → reads 1,2,3,4 in order.
- Full FIFO with simultaneous we=1 (0x0009) and pop → pop occurs, write dropped, count=3, overflow=1.
- Continuous push and pop for 10 cycles (values 0x0010..0x0019) → outputs in order, one cycle behind, pointers wrap past index 3, count steady at 1.
- Three entries plus overflow set, assert clr together with we=1 → next cycle count=0, dout_valid=0, overflow=0, write discarded.
- Assert rst_n low mid-stream with count=2 → outputs go to reset values immediately (count=0, dout_valid=0, dout=0). After release, a first write of 0x1234 appears at dout.
